// File: rtl/equiv_response_checker.sv
// Response checker for an exhaustive N_IN-input stimulus sweep: compares two circuit
// outputs per accepted vector, verifies ascending order and registers a pass/fail verdict.
module equiv_response_checker #(
    parameter int N_IN  = 4,
    parameter int N_VEC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            vec_valid,
    input  logic [N_IN-1:0] vec_in,
    input  logic            out_a,
    input  logic            out_b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            seq_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // exp_idx wraps naturally at 2**N_IN, which equals N_VEC.
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] exp_idx_q, exp_idx_d;
    logic [N_IN:0]   mismatch_count_q, mismatch_count_d;
    logic            first_fail_valid_q, first_fail_valid_d;
    logic [N_IN-1:0] first_fail_vec_q, first_fail_vec_d;
    logic            seq_error_q, seq_error_d;
    logic            pass_q, pass_d;
    logic            vec_mismatch;

    assign vec_mismatch = (out_a != out_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            exp_idx_q          <= '0;
            mismatch_count_q   <= '0;
            first_fail_valid_q <= 1'b0;
            first_fail_vec_q   <= '0;
            seq_error_q        <= 1'b0;
            pass_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            exp_idx_q          <= exp_idx_d;
            mismatch_count_q   <= mismatch_count_d;
            first_fail_valid_q <= first_fail_valid_d;
            first_fail_vec_q   <= first_fail_vec_d;
            seq_error_q        <= seq_error_d;
            pass_q             <= pass_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        exp_idx_d          = exp_idx_q;
        mismatch_count_d   = mismatch_count_q;
        first_fail_valid_d = first_fail_valid_q;
        first_fail_vec_d   = first_fail_vec_q;
        seq_error_d        = seq_error_q;
        pass_d             = pass_q;

        if (start) begin
            // start restarts from any state and masks vec_valid on the same edge.
            state_d            = S_CHECK;
            exp_idx_d          = '0;
            mismatch_count_d   = '0;
            first_fail_valid_d = 1'b0;
            first_fail_vec_d   = '0;
            seq_error_d        = 1'b0;
            pass_d             = 1'b0;
        end else if ((state_q == S_CHECK) && vec_valid) begin
            if (vec_in != exp_idx_q) begin
                seq_error_d = 1'b1;
            end
            if (vec_mismatch) begin
                mismatch_count_d = mismatch_count_q + (N_IN + 1)'(1);
                if (!first_fail_valid_q) begin
                    first_fail_valid_d = 1'b1;
                    first_fail_vec_d   = vec_in;
                end
            end
            exp_idx_d = exp_idx_q + N_IN'(1);
            if (exp_idx_q == LAST_IDX) begin
                // Verdict uses the values that include this final vector.
                state_d = S_DONE;
                pass_d  = (mismatch_count_d == '0) && !seq_error_d;
            end
        end
    end

    assign busy             = (state_q == S_CHECK);
    assign done             = (state_q == S_DONE);
    assign pass             = pass_q;
    assign mismatch_count   = mismatch_count_q;
    assign first_fail_valid = first_fail_valid_q;
    assign first_fail_vec   = first_fail_vec_q;
    assign seq_error        = seq_error_q;

endmodule

// File: tb/tb_equiv_response_checker.sv
// Bench for equiv_response_checker: hand-derived vector table for the directed scenarios,
// then randomized traffic checked against a list-based reference model.
module tb_equiv_response_checker;

    localparam int N_IN  = 4;
    localparam int N_VEC = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic            vec_valid;
    logic [N_IN-1:0] vec_in;
    logic            out_a;
    logic            out_b;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   mismatch_count;
    logic            first_fail_valid;
    logic [N_IN-1:0] first_fail_vec;
    logic            seq_error;

    equiv_response_checker #(.N_IN(N_IN), .N_VEC(N_VEC)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .vec_valid        (vec_valid),
        .vec_in           (vec_in),
        .out_a            (out_a),
        .out_b            (out_b),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_count   (mismatch_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .seq_error        (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic [4:0] mmc;
        logic       ffv;
        logic [3:0] ffvec;
        logic       seq;
    } out_t;

    typedef struct {
        bit         r;
        bit         s;
        bit         v;
        logic [3:0] vec;
        bit         a;
        bit         b;
        out_t       exp;
        int         ph;
    } vec_t;

    typedef struct {
        logic [3:0] vec;
        bit         a;
        bit         b;
    } acc_t;

    vec_t tbl[$];
    acc_t run_list[$];   // vectors accepted in the current run, in arrival order
    bit   model_running;
    bit   model_finished;
    int   n_checks;
    int   n_errors;
    int   cyc_no;

    function automatic out_t mk(input logic bz, input logic dn, input logic ps,
                                input logic [4:0] mmc, input logic ffv,
                                input logic [3:0] ffvec, input logic seq);
        out_t o;
        o.busy  = bz;
        o.done  = dn;
        o.pass  = ps;
        o.mmc   = mmc;
        o.ffv   = ffv;
        o.ffvec = ffvec;
        o.seq   = seq;
        return o;
    endfunction

    task automatic add(input int ph, input bit r, input bit s, input bit v,
                       input logic [3:0] vec, input bit a, input bit b, input out_t e);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.vec = vec; t.a = a; t.b = b; t.exp = e; t.ph = ph;
        tbl.push_back(t);
    endtask

    // Reference model: results are derived from the whole list of accepted vectors.
    task automatic model_step(input bit r, input bit s, input bit v,
                              input logic [3:0] vec, input bit a, input bit b);
        acc_t x;
        if (r) begin
            run_list.delete();
            model_running  = 1'b0;
            model_finished = 1'b0;
        end else if (s) begin
            run_list.delete();
            model_running  = 1'b1;
            model_finished = 1'b0;
        end else if (model_running && v) begin
            x.vec = vec; x.a = a; x.b = b;
            run_list.push_back(x);
            if (run_list.size() == N_VEC) begin
                model_running  = 1'b0;
                model_finished = 1'b1;
            end
        end
    endtask

    function automatic out_t model_out();
        int         mm;
        logic       ffv;
        logic [3:0] ffvec;
        logic       seq;
        mm = 0; ffv = 1'b0; ffvec = 4'd0; seq = 1'b0;
        foreach (run_list[i]) begin
            if (run_list[i].vec != 4'(i)) seq = 1'b1;
            if (run_list[i].a != run_list[i].b) begin
                mm++;
                if (!ffv) begin
                    ffv   = 1'b1;
                    ffvec = run_list[i].vec;
                end
            end
        end
        return mk(model_running, model_finished,
                  model_finished && (mm == 0) && !seq, 5'(mm), ffv, ffvec, seq);
    endfunction

    task automatic step(input bit r, input bit s, input bit v, input logic [3:0] vec,
                        input bit a, input bit b, input bit use_model, input out_t e_in,
                        input int ph);
        out_t e;
        out_t got;
        rst = r; start = s; vec_valid = v; vec_in = vec; out_a = a; out_b = b;
        @(posedge clk);
        model_step(r, s, v, vec, a, b);
        #1;
        cyc_no++;
        e   = use_model ? model_out() : e_in;
        got = {busy, done, pass, mismatch_count, first_fail_valid, first_fail_vec, seq_error};
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL ph%0d cyc%0d outputs: got busy=%0b done=%0b pass=%0b mmc=%0d ffv=%0b ffvec=%0d seq=%0b, expected busy=%0b done=%0b pass=%0b mmc=%0d ffv=%0b ffvec=%0d seq=%0b",
                     ph, cyc_no, got.busy, got.done, got.pass, got.mmc, got.ffv, got.ffvec, got.seq,
                     e.busy, e.done, e.pass, e.mmc, e.ffv, e.ffvec, e.seq);
        end else begin
            $display("ph%0d cyc%0d rst=%0b start=%0b vv=%0b vec=%0d a=%0b b=%0b -> busy=%0b done=%0b pass=%0b mmc=%0d ffv=%0b ffvec=%0d seq=%0b ok",
                     ph, cyc_no, r, s, v, vec, a, b, got.busy, got.done, got.pass, got.mmc,
                     got.ffv, got.ffvec, got.seq);
        end
    endtask

    task automatic add_clean_run(input int ph, input bit with_start);
        if (with_start) add(ph, 0, 1, 0, 4'd0, 0, 0, mk(1, 0, 0, 5'd0, 0, 4'd0, 0));
        for (int k = 0; k < N_VEC; k++)
            add(ph, 0, 0, 1, 4'(k), k[0], k[0], mk(k < 15, k == 15, k == 15, 5'd0, 0, 4'd0, 0));
    endtask

    initial begin
        out_t none;
        bit   r, s, v, a, mm;
        logic [3:0] vec;
        none = '0;
        n_checks = 0; n_errors = 0; cyc_no = 0;
        model_running = 1'b0; model_finished = 1'b0;
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_in = '0; out_a = 1'b0; out_b = 1'b0;

        // Phase 0: reset state, rst dominates start
        add(0, 1, 0, 0, 4'd0, 0, 0, none);
        add(0, 1, 1, 1, 4'd0, 0, 1, none);
        // Phase 1: clean ascending run
        add_clean_run(1, 1'b1);
        add(1, 0, 0, 0, 4'd0, 0, 0, mk(0, 1, 1, 5'd0, 0, 4'd0, 0));
        // Phase 2: mismatches at 5 and 12, then mismatching traffic in DONE is ignored
        add(2, 0, 1, 0, 4'd0, 0, 0, mk(1, 0, 0, 5'd0, 0, 4'd0, 0));
        for (int k = 0; k < N_VEC; k++)
            add(2, 0, 0, 1, 4'(k), 1, !(k == 5 || k == 12),
                mk(k < 15, k == 15, 0, (k >= 12) ? 5'd2 : (k >= 5) ? 5'd1 : 5'd0,
                   k >= 5, (k >= 5) ? 4'd5 : 4'd0, 0));
        add(2, 0, 0, 1, 4'd3, 1, 0, mk(0, 1, 0, 5'd2, 1, 4'd5, 0));
        add(2, 0, 0, 1, 4'd0, 0, 1, mk(0, 1, 0, 5'd2, 1, 4'd5, 0));
        // Phase 3: order 0,1,3,3,4..15 sets sticky seq_error
        add(3, 0, 1, 0, 4'd0, 0, 0, mk(1, 0, 0, 5'd0, 0, 4'd0, 0));
        for (int k = 0; k < N_VEC; k++)
            add(3, 0, 0, 1, (k == 2) ? 4'd3 : 4'(k), 0, 0,
                mk(k < 15, k == 15, 0, 5'd0, 0, 4'd0, k >= 2));
        // Phase 4: reset mid-run, IDLE ignores traffic, then a clean run
        add(4, 0, 1, 0, 4'd0, 0, 0, mk(1, 0, 0, 5'd0, 0, 4'd0, 0));
        for (int k = 0; k < 7; k++)
            add(4, 0, 0, 1, 4'(k), 0, k == 3,
                mk(1, 0, 0, (k >= 3) ? 5'd1 : 5'd0, k >= 3, (k >= 3) ? 4'd3 : 4'd0, 0));
        add(4, 1, 1, 1, 4'd7, 0, 1, none);
        add(4, 0, 0, 1, 4'd0, 1, 0, none);
        add(4, 0, 0, 1, 4'd9, 0, 1, none);
        add_clean_run(4, 1'b1);
        // Phase 5: restart after 9 vectors, start masks vec_valid, held start keeps restarting
        add(5, 0, 1, 0, 4'd0, 0, 0, mk(1, 0, 0, 5'd0, 0, 4'd0, 0));
        for (int k = 0; k < 9; k++)
            add(5, 0, 0, 1, 4'(k), 1, !(k == 2 || k == 6),
                mk(1, 0, 0, (k >= 6) ? 5'd2 : (k >= 2) ? 5'd1 : 5'd0,
                   k >= 2, (k >= 2) ? 4'd2 : 4'd0, 0));
        add(5, 0, 1, 1, 4'd9, 0, 1, mk(1, 0, 0, 5'd0, 0, 4'd0, 0));
        add(5, 0, 1, 1, 4'd0, 1, 0, mk(1, 0, 0, 5'd0, 0, 4'd0, 0));
        add_clean_run(5, 1'b0);

        foreach (tbl[i])
            step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].vec, tbl[i].a, tbl[i].b, 1'b0,
                 tbl[i].exp, tbl[i].ph);

        // Phase 6: gapped clean run with garbage in the gaps, then traffic in DONE
        step(0, 1, 0, 4'd0, 0, 0, 1'b1, none, 6);
        for (int k = 0; k < N_VEC; k++) begin
            for (int g = $urandom_range(1, 3); g > 0; g--)
                step(0, 0, 0, 4'($urandom_range(0, 15)), 1, 0, 1'b1, none, 6);
            step(0, 0, 1, 4'(k), k[1], k[1], 1'b1, none, 6);
        end
        step(0, 0, 1, 4'd2, 0, 1, 1'b0, mk(0, 1, 1, 5'd0, 0, 4'd0, 0), 6);
        step(0, 0, 1, 4'd5, 1, 0, 1'b1, none, 6);

        // Phase 7: randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < (model_running ? 3 : 15));
            v  = ($urandom_range(0, 99) < 60);
            vec = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'(run_list.size() % N_VEC);
            mm = ($urandom_range(0, 7) == 0);
            a  = 1'($urandom_range(0, 1));
            step(r, s, v, vec, a, a ^ mm, 1'b1, none, 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
